// File: rtl/vm_keypad_pkg.sv
// Shared keypad definitions: key codes, debounce state encoding and quantity defaults.
package vm_keypad_pkg;

    localparam logic [3:0] KEY_COUNT   = 4'h1;
    localparam logic [3:0] KEY_NONE    = 4'h0;

    localparam int         MAX_QTY_DEF = 9;
    localparam int         QTY_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB_ON,
        HELD,
        DEB_OFF
    } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Debounces one key level. accept pulses (combinationally) on the sample that
// completes DEBOUNCE_CYCLES consecutive pressed samples; a held key never repeats.
module key_debounce
    import vm_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             reached;

    // The entry sample counts as the first stable one, so the level is accepted
    // when the incremented count hits the last index.
    assign cnt_inc = cnt_q + 1'b1;
    assign reached = (cnt_inc == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = DEB_ON;
                    cnt_d   = '0;
                end
            end
            DEB_ON: begin
                if (!press) begin
                    state_d = IDLE;
                end else if (reached) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!press) begin
                    state_d = DEB_OFF;
                    cnt_d   = '0;
                end
            end
            DEB_OFF: begin
                if (press) begin
                    state_d = HELD;
                end else if (reached) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_qty_counter.sv
// Turns debounced count-key presses into a saturating quantity and hands it to the
// vending controller over a valid/ready order handshake.
module keypad_qty_counter
    import vm_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int MAX_QTY         = MAX_QTY_DEF,
    parameter int QTY_W           = QTY_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_value_count,
    input  logic             commit,
    input  logic             clear,
    input  logic             order_ready,
    output logic [QTY_W-1:0] qty,
    output logic             press_pulse,
    output logic             sat,
    output logic             order_valid,
    output logic [QTY_W-1:0] order_qty
);

    localparam logic [QTY_W-1:0] QTY_MAX = QTY_W'(MAX_QTY);

    logic             press;
    logic             accept;
    logic [QTY_W-1:0] qty_q, qty_d;
    logic [QTY_W-1:0] order_qty_q, order_qty_d;
    logic             order_valid_q, order_valid_d;
    logic             press_pulse_q, press_pulse_d;
    logic             sat_q, sat_d;

    assign press = (key_value_count == KEY_COUNT);

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .press (press),
        .accept(accept)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            qty_q         <= '0;
            order_qty_q   <= '0;
            order_valid_q <= 1'b0;
            press_pulse_q <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            qty_q         <= qty_d;
            order_qty_q   <= order_qty_d;
            order_valid_q <= order_valid_d;
            press_pulse_q <= press_pulse_d;
            sat_q         <= sat_d;
        end
    end

    // Pending order blocks everything but the handshake; a commit, even a refused
    // one, swallows a coincident press; clear zeroes but still reports the press.
    always_comb begin
        qty_d         = qty_q;
        order_qty_d   = order_qty_q;
        order_valid_d = order_valid_q;
        press_pulse_d = 1'b0;
        sat_d         = 1'b0;
        if (order_valid_q) begin
            if (order_ready) begin
                order_valid_d = 1'b0;
                qty_d         = '0;
            end
        end else if (commit) begin
            if (qty_q != '0) begin
                order_valid_d = 1'b1;
                order_qty_d   = qty_q;
            end
        end else if (clear) begin
            qty_d         = '0;
            press_pulse_d = accept;
        end else if (accept) begin
            press_pulse_d = 1'b1;
            if (qty_q < QTY_MAX) qty_d = qty_q + 1'b1;
            else                 sat_d = 1'b1;
        end
    end

    assign qty         = qty_q;
    assign press_pulse = press_pulse_q;
    assign sat         = sat_q;
    assign order_valid = order_valid_q;
    assign order_qty   = order_qty_q;

endmodule

// File: tb/tb_keypad_qty_counter.sv
// Self-checking bench: directed vector table, corner-case sequences and random
// traffic, all checked against a run-length debounce model and an order model.
module tb_keypad_qty_counter;

    localparam int D   = 4;
    localparam int MAX = 9;
    localparam int QW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    key_value_count = 4'h0;
    logic          commit = 1'b0, clear = 1'b0, order_ready = 1'b0;
    logic [QW-1:0] qty, order_qty;
    logic          press_pulse, sat, order_valid;

    int n_cmp = 0, n_err = 0;
    int pp_cnt = 0, sat_cnt = 0;

    // reference model state
    int m_level = 0, m_run = 0, m_qty = 0, m_ov = 0, m_oq = 0, m_pp = 0, m_sat = 0;

    keypad_qty_counter #(
        .DEBOUNCE_CYCLES(D), .CNT_W(20), .MAX_QTY(MAX), .QTY_W(QW)
    ) dut (
        .clk(clk), .reset(reset), .key_value_count(key_value_count),
        .commit(commit), .clear(clear), .order_ready(order_ready),
        .qty(qty), .press_pulse(press_pulse), .sat(sat),
        .order_valid(order_valid), .order_qty(order_qty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic [3:0] key, input bit cm, input bit cl,
                       input bit rdy, input bit rs);
        int press, acc;
        key_value_count = key; commit = cm; clear = cl; order_ready = rdy; reset = rs;
        m_pp = 0; m_sat = 0;
        if (rs) begin
            m_level = 0; m_run = 0; m_qty = 0; m_ov = 0; m_oq = 0;
        end else begin
            press = (key == 4'h1) ? 1 : 0;
            acc   = 0;
            // accepted level flips after D consecutive samples that disagree with it
            if (press != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = press; m_run = 0; acc = press;
                end
            end else m_run = 0;
            if (m_ov != 0) begin
                if (rdy) begin m_ov = 0; m_qty = 0; end
            end else if (cm) begin
                if (m_qty != 0) begin m_ov = 1; m_oq = m_qty; end
            end else if (cl) begin
                m_qty = 0; m_pp = acc;
            end else if (acc != 0) begin
                m_pp = 1;
                if (m_qty < MAX) m_qty++; else m_sat = 1;
            end
        end
        @(posedge clk); #1;
        if (press_pulse) pp_cnt++;
        if (sat) sat_cnt++;
        chk("qty", int'(qty), m_qty);
        chk("press_pulse", int'(press_pulse), m_pp);
        chk("sat", int'(sat), m_sat);
        chk("order_valid", int'(order_valid), m_ov);
        chk("order_qty", int'(order_qty), m_oq);
    endtask

    task automatic press_once();
        for (int i = 0; i < 5; i++) cyc(4'h1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(4'h0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic [3:0] key;
        bit         rs, cm, cl;
        int         e_qty, e_pp, e_ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] key, input bit rs, input bit cm,
                                input bit cl, input int q, input int pp, input int ov);
        vec_t v;
        v.key = key; v.rs = rs; v.cm = cm; v.cl = cl;
        v.e_qty = q; v.e_pp = pp; v.e_ov = ov;
        return v;
    endfunction

    initial begin
        // reset with key held and commit asserted: everything stays cleared
        tbl.push_back(mk(4'h1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'h1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0));
        // one clean press: pulse lands 4 cycles after the rise, no repeat
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'h1, 0, 0, 0, (i >= 3) ? 1 : 0, (i == 3) ? 1 : 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'h0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0));
        // short glitch and a foreign key code never count
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'h1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)  tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'h2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].key, tbl[i].cm, tbl[i].cl, 0, tbl[i].rs);
            chk("tbl_qty", int'(qty), tbl[i].e_qty);
            chk("tbl_pp", int'(press_pulse), tbl[i].e_pp);
            chk("tbl_ov", int'(order_valid), tbl[i].e_ov);
        end

        // saturation at MAX
        pp_cnt = 0; sat_cnt = 0;
        for (int i = 0; i < 9; i++) press_once();
        chk("sat9_qty", int'(qty), 9);
        chk("sat9_pp", pp_cnt, 9);
        chk("sat9_sat", sat_cnt, 0);
        press_once();
        chk("sat10_qty", int'(qty), 9);
        chk("sat10_pp", pp_cnt, 10);
        chk("sat10_sat", sat_cnt, 1);

        // commit, blocked press/clear while pending, handshake
        cyc(4'h0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) press_once();
        chk("pre_commit_qty", int'(qty), 3);
        cyc(4'h0, 1, 0, 0, 0);
        chk("commit_ov", int'(order_valid), 1);
        chk("commit_oq", int'(order_qty), 3);
        pp_cnt = 0;
        press_once();
        cyc(4'h0, 0, 1, 0, 0);
        chk("pend_qty", int'(qty), 3);
        chk("pend_pp", pp_cnt, 0);
        cyc(4'h0, 0, 0, 1, 0);
        chk("hs_ov", int'(order_valid), 0);
        chk("hs_qty", int'(qty), 0);
        chk("hs_oq", int'(order_qty), 3);

        // commit with zero quantity is refused
        cyc(4'h0, 1, 0, 0, 0);
        chk("zero_commit_ov", int'(order_valid), 0);

        // reset mid-debounce drops the press
        pp_cnt = 0;
        cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(4'h0, 0, 0, 0, 0);
        chk("rst_mid_pp", pp_cnt, 0);
        chk("rst_mid_qty", int'(qty), 0);

        // commit coinciding with accept uses the pre-increment quantity
        press_once(); press_once();
        pp_cnt = 0;
        for (int i = 0; i < 3; i++) cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 1, 0, 0, 0);
        chk("cm_acc_oq", int'(order_qty), 2);
        chk("cm_acc_ov", int'(order_valid), 1);
        chk("cm_acc_pp", pp_cnt, 0);
        for (int i = 0; i < 5; i++) cyc(4'h0, 0, 0, 0, 0);
        cyc(4'h0, 0, 0, 1, 0);
        chk("cm_acc_hs_qty", int'(qty), 0);

        // random traffic: key held in runs, sparse control pulses
        begin
            logic [3:0] k;
            int len;
            bit cm, cl, rdy, rs;
            k = 4'h0; len = 0;
            for (int c = 0; c < 4000; c++) begin
                if (len == 0) begin
                    case ($urandom_range(0, 5))
                        0, 1, 2: k = 4'h1;
                        3, 4:    k = 4'h0;
                        default: k = 4'($urandom_range(2, 15));
                    endcase
                    len = $urandom_range(1, 9);
                end
                len--;
                cm  = ($urandom_range(0, 15) == 0);
                cl  = !cm && ($urandom_range(0, 15) == 0);
                rdy = ($urandom_range(0, 3) == 0);
                rs  = ($urandom_range(0, 499) == 0);
                cyc(k, cm, cl, rdy, rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
